// File: rtl/uart_cmd_link_ctrl.sv
// Command link controller: sends host and heartbeat command bytes to a remote
// FPGA over a UART pair and confirms each byte by echo. The controller retries
// failed attempts, spaces every attempt with an idle gap, and tracks link
// health as a link_up flag plus a saturating error count.
module uart_cmd_link_ctrl #(
  parameter int unsigned ECHO_TIMEOUT = 240000,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned GAP_CYCLES   = 2400,
  parameter int unsigned HB_PERIOD    = 24000000,
  parameter logic [7:0]  HB_CMD       = 8'hC3
) (
  input  logic       clk,
  input  logic       reset,
  // Host command interface
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       cmd_done,
  output logic       cmd_fail,
  input  logic       hb_enable,
  // UART transmitter
  output logic       start_tx,
  output logic [7:0] data_to_tx,
  input  logic       tx_busy,
  // UART receiver
  input  logic       rx_done,
  input  logic [7:0] data_received,
  input  logic       parity_error,
  // Link status
  output logic       link_up,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    StIdle,
    StTxStart,
    StTxWait,
    StEchoWait,
    StGap
  } state_e;

  localparam logic [17:0] TmoLast  = 18'(ECHO_TIMEOUT - 1);
  localparam logic [17:0] GapLast  = 18'(GAP_CYCLES - 1);
  localparam logic [24:0] HbLast   = 25'(HB_PERIOD - 1);
  localparam logic [7:0]  RetryMax = 8'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [7:0]  byte_q, byte_d;           // byte of the transaction in flight
  logic        req_host_q, req_host_d;   // 1: host owns the transaction
  logic        last_hb_q, last_hb_d;     // 1: heartbeat got the latest grant
  logic        hb_pend_q, hb_pend_d;
  logic [24:0] hb_cnt_q, hb_cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic [17:0] tmo_q, tmo_d;
  logic [17:0] gap_q, gap_d;
  logic        gap_to_tx_q, gap_to_tx_d; // gap ends in a retry rather than idle
  logic        start_tx_q, start_tx_d;
  logic        done_q, done_d;
  logic        fail_q, fail_d;
  logic        link_up_q, link_up_d;
  logic [7:0]  err_q, err_d;

  logic host_win, hb_win, hb_wrap, hb_clear, attempt_ok, attempt_fail;

  // Host wins unless a heartbeat is pending and the host was served last.
  assign host_win = cmd_valid && (!hb_pend_q || last_hb_q);
  assign hb_win   = !host_win && hb_pend_q;

  // Ready is held low during reset so nothing is accepted before the FSM runs.
  assign cmd_ready  = reset && (state_q == StIdle) && (!hb_pend_q || last_hb_q);
  assign start_tx   = start_tx_q;
  assign data_to_tx = byte_q;
  assign cmd_done   = done_q;
  assign cmd_fail   = fail_q;
  assign link_up    = link_up_q;
  assign err_count  = err_q;

  // Next-state logic: heartbeat timer, arbitration, attempt sequencing.
  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    req_host_d   = req_host_q;
    last_hb_d    = last_hb_q;
    hb_pend_d    = hb_pend_q;
    hb_cnt_d     = hb_cnt_q;
    retry_d      = retry_q;
    tmo_d        = tmo_q;
    gap_d        = gap_q;
    gap_to_tx_d  = gap_to_tx_q;
    done_d       = 1'b0;
    fail_d       = 1'b0;
    link_up_d    = link_up_q;
    err_d        = err_q;
    hb_wrap      = 1'b0;
    hb_clear     = 1'b0;
    attempt_ok   = 1'b0;
    attempt_fail = 1'b0;

    if (!hb_enable) begin
      hb_cnt_d = '0;
    end else if (hb_cnt_q == HbLast) begin
      hb_cnt_d = '0;
      hb_wrap  = 1'b1;
    end else begin
      hb_cnt_d = hb_cnt_q + 25'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (host_win || hb_win) begin
          byte_d     = host_win ? cmd_data : HB_CMD;
          req_host_d = host_win;
          last_hb_d  = !host_win;
          hb_clear   = hb_win;
          retry_d    = '0;
          tmo_d      = '0;
          state_d    = StTxStart;
        end
      end
      StTxStart: begin
        // The transmitter must acknowledge within the same budget as the echo.
        if (tx_busy) begin
          state_d = StTxWait;
        end else if (tmo_q == TmoLast) begin
          attempt_fail = 1'b1;
        end else begin
          tmo_d = tmo_q + 18'd1;
        end
      end
      StTxWait: begin
        if (!tx_busy) begin
          tmo_d   = '0;
          state_d = StEchoWait;
        end
      end
      StEchoWait: begin
        // A matching echo on the timeout cycle still counts as success.
        if (rx_done && !parity_error && (data_received == byte_q)) begin
          attempt_ok = 1'b1;
        end else if (rx_done) begin
          attempt_fail = 1'b1;
        end else if (tmo_q == TmoLast) begin
          attempt_fail = 1'b1;
        end else begin
          tmo_d = tmo_q + 18'd1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          gap_d   = '0;
          tmo_d   = '0;
          state_d = gap_to_tx_q ? StTxStart : StIdle;
        end else begin
          gap_d = gap_q + 18'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (attempt_ok) begin
      link_up_d   = 1'b1;
      done_d      = req_host_q;
      gap_to_tx_d = 1'b0;
      gap_d       = '0;
      state_d     = StGap;
    end

    if (attempt_fail) begin
      if (retry_q < RetryMax) begin
        retry_d     = retry_q + 8'd1;
        gap_to_tx_d = 1'b1;
      end else begin
        link_up_d   = 1'b0;
        err_d       = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
        fail_d      = req_host_q;
        gap_to_tx_d = 1'b0;
      end
      gap_d   = '0;
      state_d = StGap;
    end

    // A wrap coinciding with a heartbeat grant keeps the request pending.
    if (!hb_enable) begin
      hb_pend_d = 1'b0;
    end else begin
      if (hb_clear) hb_pend_d = 1'b0;
      if (hb_wrap)  hb_pend_d = 1'b1;
    end

    start_tx_d = (state_d == StTxStart);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      byte_q      <= '0;
      req_host_q  <= 1'b0;
      last_hb_q   <= 1'b1;
      hb_pend_q   <= 1'b0;
      hb_cnt_q    <= '0;
      retry_q     <= '0;
      tmo_q       <= '0;
      gap_q       <= '0;
      gap_to_tx_q <= 1'b0;
      start_tx_q  <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      link_up_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      req_host_q  <= req_host_d;
      last_hb_q   <= last_hb_d;
      hb_pend_q   <= hb_pend_d;
      hb_cnt_q    <= hb_cnt_d;
      retry_q     <= retry_d;
      tmo_q       <= tmo_d;
      gap_q       <= gap_d;
      gap_to_tx_q <= gap_to_tx_d;
      start_tx_q  <= start_tx_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      link_up_q   <= link_up_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_link_ctrl.sv
// Directed bench for uart_cmd_link_ctrl with a behavioural UART peer.
module tb_uart_cmd_link_ctrl;

  localparam int unsigned TMO = 2000;
  localparam int unsigned GAP = 50;
  localparam int unsigned HBP = 1000;
  localparam int unsigned MR  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       hb_enable = 1'b0;
  logic       tx_busy = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] data_received = 8'h00;
  logic       parity_error = 1'b0;
  logic       cmd_ready, cmd_done, cmd_fail, start_tx, link_up;
  logic [7:0] data_to_tx, err_count;

  uart_cmd_link_ctrl #(
    .ECHO_TIMEOUT(TMO),
    .MAX_RETRY   (MR),
    .GAP_CYCLES  (GAP),
    .HB_PERIOD   (HBP),
    .HB_CMD      (8'hC3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .cmd_done     (cmd_done),
    .cmd_fail     (cmd_fail),
    .hb_enable    (hb_enable),
    .start_tx     (start_tx),
    .data_to_tx   (data_to_tx),
    .tx_busy      (tx_busy),
    .rx_done      (rx_done),
    .data_received(data_received),
    .parity_error (parity_error),
    .link_up      (link_up),
    .err_count    (err_count)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Peer behaviour knobs: 0 no echo, 1 exact echo, 2 corrupted echo.
  int echo_mode = 1;
  int echo_delay = 20;
  int par_idx = -1;
  int model_tx_cnt = 0;

  // UART peer: busy 2 cycles after start, for 10 cycles, then optional echo.
  initial begin
    logic [7:0] b;
    int         my_tx;
    forever begin
      @(negedge clk);
      if (start_tx && !tx_busy) begin
        b = data_to_tx;
        my_tx = model_tx_cnt;
        model_tx_cnt++;
        repeat (2) @(negedge clk);
        tx_busy = 1'b1;
        repeat (10) @(negedge clk);
        tx_busy = 1'b0;
        if (echo_mode != 0) begin
          repeat (echo_delay) @(negedge clk);
          data_received = (echo_mode == 2) ? (b ^ 8'h01) : b;
          parity_error = (my_tx == par_idx);
          rx_done = 1'b1;
          @(negedge clk);
          rx_done = 1'b0;
          parity_error = 1'b0;
        end
      end
    end
  end

  // Observation queues, written only by this monitor.
  logic [7:0] obs_tx_q[$];
  int         obs_tx_cyc[$];
  int         obs_hi_q[$];
  int         obs_evt_q[$];   // 1 = cmd_done, 2 = cmd_fail

  initial begin
    logic st_prev;
    int   hi_len;
    st_prev = 1'b0;
    hi_len = 0;
    forever begin
      @(negedge clk);
      if (start_tx && !st_prev) begin
        obs_tx_q.push_back(data_to_tx);
        obs_tx_cyc.push_back(cyc);
        hi_len = 0;
      end
      if (start_tx) hi_len++;
      if (!start_tx && st_prev) obs_hi_q.push_back(hi_len);
      st_prev = start_tx;
      if (cmd_done) obs_evt_q.push_back(1);
      if (cmd_fail) obs_evt_q.push_back(2);
    end
  end

  // Scoreboard: expectations pushed when stimulus is driven.
  logic [7:0] exp_tx_q[$];
  int         exp_evt_q[$];
  int         tx_rd = 0;
  int         hi_rd = 0;
  int         evt_rd = 0;
  int         n_cmp = 0;
  int         n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_seen", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_data = b;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Compare transmitted bytes, spacing between retries and start_tx width.
  task automatic drain_tx(input string nm, input int sp);
    logic [7:0] e;
    logic [31:0] o;
    int first;
    first = tx_rd;
    while (exp_tx_q.size() > 0) begin
      e = exp_tx_q.pop_front();
      o = (tx_rd < obs_tx_q.size()) ? {24'd0, obs_tx_q[tx_rd]} : 32'hFFFF_FFFF;
      chk({nm, "_tx_byte"}, o, {24'd0, e});
      if (tx_rd > first && tx_rd < obs_tx_q.size())
        chk({nm, "_spacing"}, obs_tx_cyc[tx_rd] - obs_tx_cyc[tx_rd-1], sp);
      tx_rd++;
    end
    chk({nm, "_tx_count"}, obs_tx_q.size(), tx_rd);
    while (hi_rd < obs_hi_q.size()) begin
      chk({nm, "_start_len"}, obs_hi_q[hi_rd], 3);
      hi_rd++;
    end
  endtask

  task automatic finish_txn(input string nm, input logic exp_link, input logic [7:0] exp_err,
                            input int sp);
    int n;
    int e;
    int o;
    n = 0;
    while (obs_evt_q.size() <= evt_rd && n < 40000) begin
      @(negedge clk);
      n++;
    end
    while (exp_evt_q.size() > 0) begin
      e = exp_evt_q.pop_front();
      o = (obs_evt_q.size() > evt_rd) ? obs_evt_q[evt_rd] : 0;
      if (obs_evt_q.size() > evt_rd) evt_rd++;
      chk({nm, "_event"}, o, e);
    end
    chk({nm, "_link_up"}, {31'd0, link_up}, {31'd0, exp_link});
    chk({nm, "_err_count"}, {24'd0, err_count}, {24'd0, exp_err});
    drain_tx(nm, sp);
    repeat (GAP + 20) @(negedge clk);
    chk({nm, "_evt_extra"}, obs_evt_q.size(), evt_rd);
  endtask

  initial begin
    int hb_base;
    int n_c3;
    int n_a5;
    int n_done;
    int n;
    bit alt_ok;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_start_tx", {31'd0, start_tx}, 32'd0);
    chk("rst_data_to_tx", {24'd0, data_to_tx}, 32'd0);
    chk("rst_done_fail", {30'd0, cmd_done, cmd_fail}, 32'd0);
    chk("rst_link_up", {31'd0, link_up}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    reset = 1'b1;

    // Clean echo after 1000 cycles
    echo_mode = 1;
    echo_delay = 1000;
    exp_tx_q.push_back(8'hEE);
    exp_evt_q.push_back(1);
    send_cmd(8'hEE);
    finish_txn("echo_ok", 1'b1, 8'd0, 0);

    // Corrupted echo on every attempt: 1 + MR transmissions then fail
    echo_mode = 2;
    echo_delay = 20;
    for (int i = 0; i <= int'(MR); i++) exp_tx_q.push_back(8'h55);
    exp_evt_q.push_back(2);
    send_cmd(8'h55);
    finish_txn("mismatch", 1'b0, 8'd1, 33 + GAP);

    // No echo at all: each attempt times out TMO cycles after tx_busy falls
    echo_mode = 0;
    for (int i = 0; i <= int'(MR); i++) exp_tx_q.push_back(8'hEE);
    exp_evt_q.push_back(2);
    send_cmd(8'hEE);
    finish_txn("timeout", 1'b0, 8'd2, 13 + TMO + GAP);

    // Parity error on first attempt, clean echo on retry
    echo_mode = 1;
    par_idx = model_tx_cnt;
    exp_tx_q.push_back(8'h3C);
    exp_tx_q.push_back(8'h3C);
    exp_evt_q.push_back(1);
    send_cmd(8'h3C);
    finish_txn("parity", 1'b1, 8'd2, 33 + GAP);

    // Heartbeat interleaved with a continuous host stream
    hb_base = obs_tx_q.size();
    @(negedge clk);
    hb_enable = 1'b1;
    cmd_data = 8'hA5;
    cmd_valid = 1'b1;
    repeat (3500) @(negedge clk);
    cmd_valid = 1'b0;
    hb_enable = 1'b0;
    repeat (300) @(negedge clk);
    n_c3 = 0;
    n_a5 = 0;
    alt_ok = 1'b1;
    for (int i = hb_base; i < obs_tx_q.size(); i++) begin
      if (obs_tx_q[i] == 8'hC3) begin
        n_c3++;
        if (i == hb_base || obs_tx_q[i-1] != 8'hA5) alt_ok = 1'b0;
      end else if (obs_tx_q[i] == 8'hA5) begin
        n_a5++;
      end
    end
    n_done = 0;
    for (int i = evt_rd; i < obs_evt_q.size(); i++) if (obs_evt_q[i] == 1) n_done++;
    chk("hb_sent_ge2", {31'd0, n_c3 >= 2}, 32'd1);
    chk("hb_alternation", {31'd0, alt_ok}, 32'd1);
    chk("hb_host_done_count", n_done, n_a5);
    chk("hb_total_events", obs_evt_q.size() - evt_rd, n_a5);
    chk("hb_link_up", {31'd0, link_up}, 32'd1);
    tx_rd = obs_tx_q.size();
    evt_rd = obs_evt_q.size();
    while (hi_rd < obs_hi_q.size()) begin
      chk("hb_start_len", obs_hi_q[hi_rd], 3);
      hi_rd++;
    end

    // Reset during ECHO_WAIT drops the command silently
    echo_mode = 0;
    exp_tx_q.push_back(8'hEE);
    send_cmd(8'hEE);
    n = 0;
    while (!tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (tx_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_rst_reached_echo", {31'd0, n < 200}, 32'd1);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_start_tx", {31'd0, start_tx}, 32'd0);
    chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("mid_rst_link_up", {31'd0, link_up}, 32'd0);
    chk("mid_rst_err_count", {24'd0, err_count}, 32'd0);
    chk("mid_rst_data_to_tx", {24'd0, data_to_tx}, 32'd0);
    reset = 1'b1;
    repeat (TMO + GAP + 50) @(negedge clk);
    chk("mid_rst_no_pulse", obs_evt_q.size(), evt_rd);
    drain_tx("mid_rst", 0);

    // Next command after reset is accepted and completes
    echo_mode = 1;
    exp_tx_q.push_back(8'h5A);
    exp_evt_q.push_back(1);
    send_cmd(8'h5A);
    finish_txn("post_rst", 1'b1, 8'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_cmd_link_ctrl.md
Name: uart_cmd_link_ctrl

Overview:
Sequences command bytes over the shared uart_tx/uart_rx pair from the main FPGA to an FPGA_modulo submodule and verifies each one by echo. Arbitrates round-robin between host commands (from top-level control) and an internal periodic heartbeat command. Each attempt is bounded by a timeout and retried a fixed number of times. Reports per-command pass/fail, link status and a saturating error count.

Parameters:
ECHO_TIMEOUT, 240000, cycles to wait for the echo after tx_busy falls (10 ms at 24 MHz)
MAX_RETRY, 3, retries after the first attempt (total attempts = 1+MAX_RETRY)
GAP_CYCLES, 2400, idle cycles between any two attempts or commands
HB_PERIOD, 24000000, heartbeat interval in cycles (1 s at 24 MHz)
HB_CMD, 8'hC3, heartbeat byte (toggle command)

Ports:
clk  input  1  system clock (24 MHz HFOSC)
reset  input  1  synchronous reset, active-low (reset=0 resets on the next clk edge)
cmd_valid  input  1  host command request
cmd_data  input  8  host command byte
cmd_ready  output  1  host command accepted when cmd_valid&cmd_ready
cmd_done  output  1  1-cycle pulse: host command echoed correctly
cmd_fail  output  1  1-cycle pulse: host command exhausted retries
hb_enable  input  1  enables heartbeat generation
start_tx  output  1  to uart_tx
data_to_tx  output  8  to uart_tx
tx_busy  input  1  from uart_tx
rx_done  input  1  from uart_rx, 1-cycle pulse
data_received  input  8  from uart_rx
parity_error  input  1  from uart_rx, qualified by rx_done
link_up  output  1  last completed transaction (host or heartbeat) succeeded
err_count  output  8  saturating count of failed transactions (host or heartbeat)

Behaviour:
- Reset values: cmd_ready=0, cmd_done=0, cmd_fail=0, start_tx=0, data_to_tx=0, link_up=0, err_count=0, state=IDLE, hb_pending=0, hb counter=0, last_grant=HB, retry count=0.
- States: IDLE, TX_START, TX_WAIT, ECHO_WAIT, GAP.
- Heartbeat timer: counts while hb_enable=1. Sets hb_pending at HB_PERIOD-1, then wraps to 0. Further wraps while already pending coalesce into the single pending request. hb_enable=0 clears the counter and hb_pending.
- IDLE arbitration, host vs heartbeat:
  - Host wins if cmd_valid and (!hb_pending or last_grant==HB).
  - Otherwise the heartbeat wins if hb_pending.
  - cmd_ready=1 only in IDLE when the host would win. It is combinational on state/hb_pending/last_grant and does not depend on cmd_valid.
- On grant (cycle N): latch the byte (cmd_data or HB_CMD), record the requester, set last_grant, clear hb_pending if the heartbeat was granted, set retry count=0. TX_START is entered at N+1.
- TX_START: start_tx=1, data_to_tx=latched byte. start_tx is held until tx_busy=1 is sampled, then it drops to 0 on the next edge and the state moves to TX_WAIT. If tx_busy never rises within ECHO_TIMEOUT cycles, the attempt counts as failed.
- TX_WAIT: wait for tx_busy=0, then load the timeout counter and enter ECHO_WAIT.
- ECHO_WAIT outcomes:
  - Success: rx_done=1, parity_error=0 and data_received==latched byte.
  - Failed attempt: rx_done with a mismatch or a parity error.
  - Failed attempt: counter reaches ECHO_TIMEOUT with no rx_done.
- rx_done in any other state is ignored.
- On success:
  - Set link_up=1.
  - Pulse cmd_done for a host transaction.
  - Enter GAP.
- On a failed attempt with retry count < MAX_RETRY: increment the retry count, enter GAP, then return to TX_START with the same byte.
- On a failed attempt with retries exhausted:
  - Set link_up=0.
  - Increment err_count, saturating at 255.
  - Pulse cmd_fail for a host transaction.
  - Enter GAP, then IDLE.
- GAP lasts exactly GAP_CYCLES cycles with start_tx=0. cmd_ready=0 outside IDLE.
- Simultaneous events:
  - rx_done in the same cycle the timeout expires is treated as success if it matches.
  - The heartbeat wrap in the same cycle as a heartbeat grant leaves hb_pending=1 (set wins).
- Reset mid-operation: start_tx=0 at the next edge, no cmd_done/cmd_fail pulse, and an in-flight host command is dropped.
- Counters: the timeout and gap counters are 18 bits, and the heartbeat counter is 25 bits. All have explicit compare-and-clear, with no reliance on overflow.

Test Plan:
- Host byte 8'hEE, uart loopback echo after 1000 cycles -> start_tx high until tx_busy, cmd_done pulse once, link_up=1, err_count=0.
- Host 8'h55, echo returns 8'h54 on every attempt -> 4 transmissions separated by ≥2400 idle cycles, then cmd_fail pulse, link_up=0, err_count=1.
- Host 8'hEE, no rx_done at all -> each attempt times out at 240000 cycles after tx_busy falls, 4 attempts, cmd_fail, err_count=1.
- hb_enable=1 with a continuous host cmd_valid stream (HB_PERIOD=1000 in the bench) -> grants alternate host/HB/host whenever hb_pending, and HB byte 8'hC3 is sent.
- First attempt with parity_error=1 and correct data, second attempt clean echo -> exactly 2 transmissions, then cmd_done.
- Reset driven low during ECHO_WAIT, then released -> all outputs at reset values, no done/fail pulse, next cmd_valid accepted in IDLE.
